alu_mc: RTL and testbench

- Multi-cycle, parametrised-width successor to the CPU's single-cycle ALU. It accepts the same 5-bit ISA opcodes and decodes them to a 3-bit internal ALU op.
- Logic and add/sub ops complete in 1 cycle. MUL and DIV run iteratively, one bit per cycle.
- Valid/ready handshakes on both sides let the execute stage stall on long ops.
- Sits in the EX stage between the operand muxes and the EX/MEM register.

---
 rtl/alu_mc.sv | 197 +++++++++++++++++++
 tb/tb_alu_mc.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Brief    : Multi-cycle EX-stage ALU with valid/ready handshakes. Logic and
//            add/sub finish in one cycle; MUL (shift-add) and DIV (restoring)
//            iterate one bit per cycle. Optional build macro ALU_OVERFLOW_EN
//            adds a signed-overflow flag as flags[2].
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
`ifdef ALU_OVERFLOW_EN
    output logic [2:0]       flags,
`else
    output logic [1:0]       flags,
`endif
    output logic             div_zero,
    output logic [2:0]       op
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_MUL = 3'b010;
    localparam logic [2:0] c_OP_DIV = 3'b011;
    localparam logic [2:0] c_OP_AND = 3'b100;
    localparam logic [2:0] c_OP_OR  = 3'b101;
    localparam logic [2:0] c_OP_XOR = 3'b110;
    localparam logic [2:0] c_OP_NOT = 3'b111;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_MUL  = 2'd1;
    localparam logic [1:0] c_S_DIV  = 2'd2;
    localparam logic [1:0] c_S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_d;
    logic [1:0]       w_accept_tgt;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic             r_dz;

    logic [2:0]       w_dec;
    logic             w_accept;
    logic             w_b_zero;
    logic             w_dz;
    logic             w_iter;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_single;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH-1:0] w_rem_sh;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic             w_rem_ge;

    always_comb begin
        w_dec = c_OP_ADD;
        case (opcode)
            5'b00010, 5'b00011, 5'b11101, 5'b11100: w_dec = c_OP_ADD;
            5'b00100, 5'b00101, 5'b10010:           w_dec = c_OP_SUB;
            5'b00110:                               w_dec = c_OP_MUL;
            5'b01000:                               w_dec = c_OP_DIV;
            5'b01010, 5'b01011, 5'b00111, 5'b11110: w_dec = c_OP_AND;
            5'b01100, 5'b01101:                     w_dec = c_OP_OR;
            5'b10000, 5'b10001:                     w_dec = c_OP_XOR;
            5'b01110:                               w_dec = c_OP_NOT;
            default:                                w_dec = c_OP_ADD;
        endcase
    end

    assign w_b_zero = (b == '0);
    assign w_dz     = (w_dec == c_OP_DIV) && w_b_zero;
    assign w_iter   = (w_dec == c_OP_MUL) || ((w_dec == c_OP_DIV) && !w_b_zero);
    assign in_ready = !rst && ((r_state == c_S_IDLE) ||
                               ((r_state == c_S_DONE) && out_ready));
    assign w_accept = in_valid && in_ready;
    assign w_sum    = a + b;
    assign w_diff   = a - b;

    // DIV only reaches this path with a zero divisor, which returns all ones.
    always_comb begin
        w_single = w_sum;
        case (w_dec)
            c_OP_SUB: w_single = w_diff;
            c_OP_DIV: w_single = '1;
            c_OP_AND: w_single = a & b;
            c_OP_OR:  w_single = a | b;
            c_OP_XOR: w_single = a ^ b;
            c_OP_NOT: w_single = ~a;
            default:  w_single = w_sum;
        endcase
    end

    // The remainder is always below the divisor, so its shifted-out MSB
    // alone proves the shifted value is large enough to subtract.
    assign w_mul_acc = r_acc + (r_q[0] ? r_m : '0);
    assign w_rem_sh  = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_rem_ge  = r_acc[WIDTH-1] || (w_rem_sh >= r_m);
    assign w_rem_nx  = w_rem_ge ? (w_rem_sh - r_m) : w_rem_sh;
    assign w_quo_nx  = {r_q[WIDTH-2:0], w_rem_ge};

    assign w_accept_tgt = (w_dec == c_OP_MUL) ? c_S_MUL :
                          (w_iter ? c_S_DIV : c_S_DONE);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            c_S_IDLE: if (w_accept) w_state_d = w_accept_tgt;
            c_S_MUL:  if (r_cnt == '0) w_state_d = c_S_DONE;
            c_S_DIV:  if (r_cnt == '0) w_state_d = c_S_DONE;
            c_S_DONE: if (out_ready) w_state_d = w_accept ? w_accept_tgt : c_S_IDLE;
            default:  w_state_d = c_S_IDLE;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    logic r_ovf;
    logic w_ovf;

    always_comb begin
        w_ovf = 1'b0;
        case (w_dec)
            c_OP_ADD: w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            c_OP_SUB: w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            default:  w_ovf = 1'b0;
        endcase
    end

    assign flags = {r_ovf, r_res[WIDTH-1], (r_res == '0)};
`else
    assign flags = {r_res[WIDTH-1], (r_res == '0)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_m     <= '0;
            r_q     <= '0;
            r_acc   <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_op    <= c_OP_ADD;
            r_dz    <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_op  <= w_dec;
                r_dz  <= w_dz;
                r_m   <= (w_dec == c_OP_DIV) ? b : a;
                r_q   <= (w_dec == c_OP_DIV) ? a : b;
                r_acc <= '0;
                r_cnt <= CNT_W'(WIDTH - 1);
                if (!w_iter) r_res <= w_single;
`ifdef ALU_OVERFLOW_EN
                r_ovf <= w_ovf;
`endif
            end else if (r_state == c_S_MUL) begin
                r_acc <= w_mul_acc;
                r_m   <= r_m << 1;
                r_q   <= r_q >> 1;
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == '0) r_res <= w_mul_acc;
            end else if (r_state == c_S_DIV) begin
                r_acc <= w_rem_nx;
                r_q   <= w_quo_nx;
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == '0) r_res <= w_quo_nx;
            end
        end
    end

    assign out_valid = (r_state == c_S_DONE);
    assign alu_out   = r_res;
    assign div_zero  = r_dz;
    assign op        = r_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Brief    : Directed bench for alu_mc with a reference model and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    localparam int W = 32;
`ifdef ALU_OVERFLOW_EN
    localparam int FLW = 3;
`else
    localparam int FLW = 2;
`endif

    logic           clk       = 1'b0;
    logic           rst       = 1'b1;
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b1;
    logic [4:0]     opcode    = '0;
    logic [W-1:0]   a         = '0;
    logic [W-1:0]   b         = '0;
    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   alu_out;
    logic [FLW-1:0] flags;
    logic           div_zero;
    logic [2:0]     op;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .flags     (flags),
        .div_zero  (div_zero),
        .op        (op)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [2:0]     op;
        logic [W-1:0]   res;
        logic [FLW-1:0] fl;
        logic           dz;
        int             due;
    } exp_t;

    function automatic exp_t model(input logic [4:0] opc, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input int now);
        exp_t   e;
        longint s;
        longint lim;
        logic   ovf;
        case (opc)
            5'b00100, 5'b00101, 5'b10010:           e.op = 3'd1;
            5'b00110:                               e.op = 3'd2;
            5'b01000:                               e.op = 3'd3;
            5'b01010, 5'b01011, 5'b00111, 5'b11110: e.op = 3'd4;
            5'b01100, 5'b01101:                     e.op = 3'd5;
            5'b10000, 5'b10001:                     e.op = 3'd6;
            5'b01110:                               e.op = 3'd7;
            default:                                e.op = 3'd0;
        endcase
        case (e.op)
            3'd0:    e.res = x + y;
            3'd1:    e.res = x - y;
            3'd2:    e.res = x * y;
            3'd3:    e.res = (y == '0) ? '1 : x / y;
            3'd4:    e.res = x & y;
            3'd5:    e.res = x | y;
            3'd6:    e.res = x ^ y;
            default: e.res = ~x;
        endcase
        lim = longint'(1) << (W - 1);
        s   = (e.op == 3'd1) ? longint'($signed(x)) - longint'($signed(y))
                             : longint'($signed(x)) + longint'($signed(y));
        ovf = (e.op <= 3'd1) && ((s >= lim) || (s < -lim));
`ifdef ALU_OVERFLOW_EN
        e.fl = {ovf, e.res[W-1], (e.res == '0)};
`else
        e.fl = {e.res[W-1], (e.res == '0)};
        if (ovf) e.fl = e.fl;
`endif
        e.dz  = (e.op == 3'd3) && (y == '0);
        e.due = now + (((e.op == 3'd2) || ((e.op == 3'd3) && (y != '0))) ? W + 1 : 1);
        return e;
    endfunction

    exp_t q[$];
    bit   rst_prev  = 1'b0;
    bit   after_rst = 1'b1;

    // Scoreboard: handshakes and outputs are sampled on the falling edge.
    always @(negedge clk) begin
        bit exp_v;
        cyc++;
        if (rst) begin
            chk("in_ready_during_rst", 64'(in_ready), 64'(0));
            if (rst_prev) begin
                chk("rst_out_valid", 64'(out_valid), 64'(0));
                chk("rst_alu_out", 64'(alu_out), 64'(0));
                chk("rst_flags", 64'(flags), 64'(1));
            end
            q.delete();
            rst_prev  = 1'b1;
            after_rst = 1'b1;
        end else begin
            rst_prev = 1'b0;
            if (after_rst) begin
                chk("idle_alu_out", 64'(alu_out), 64'(0));
                chk("idle_flags", 64'(flags), 64'(1));
                chk("idle_div_zero", 64'(div_zero), 64'(0));
                chk("idle_op", 64'(op), 64'(0));
            end
            exp_v = (q.size() != 0) && (cyc >= q[0].due);
            chk("sb_out_valid", 64'(out_valid), 64'(exp_v));
            chk("sb_in_ready", 64'(in_ready), 64'((q.size() == 0) || (exp_v && out_ready)));
            if (exp_v && out_valid) begin
                chk("sb_alu_out", 64'(alu_out), 64'(q[0].res));
                chk("sb_flags", 64'(flags), 64'(q[0].fl));
                chk("sb_div_zero", 64'(div_zero), 64'(q[0].dz));
                chk("sb_op", 64'(op), 64'(q[0].op));
            end
            if (exp_v && out_ready) void'(q.pop_front());
            if (in_valid && in_ready) begin
                q.push_back(model(opcode, a, b, cyc));
                after_rst = 1'b0;
            end
        end
    end

    task automatic do_op(input string nm, input logic [4:0] opc, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [2:0] eop, input logic [W-1:0] eres,
                         input logic [1:0] efl, input logic edz, input int elat);
        bit got;
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; opcode = opc; a = x; b = y;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        chk({nm, "_accepted"}, 64'(got), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; opcode = 5'($urandom); a = $urandom; b = $urandom;
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            n++;
            got = out_valid;
        end
        chk({nm, "_latency"}, 64'(n), 64'(elat));
        chk({nm, "_res"}, 64'(alu_out), 64'(eres));
        chk({nm, "_op"}, 64'(op), 64'(eop));
        chk({nm, "_flags"}, 64'(flags[1:0]), 64'(efl));
        chk({nm, "_dz"}, 64'(div_zero), 64'(edz));
    endtask

    logic [4:0]   sw_opc [18] = '{5'b00010, 5'b00011, 5'b11101, 5'b11100, 5'b00100, 5'b00101,
                                  5'b10010, 5'b01010, 5'b01011, 5'b00111, 5'b11110, 5'b01100,
                                  5'b01101, 5'b10000, 5'b10001, 5'b01110, 5'b00000, 5'b11111};
    logic [2:0]   sw_op  [18] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd4, 3'd4,
                                  3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd0, 3'd0};
    logic [W-1:0] sw_res [18] = '{32'h16, 32'h16, 32'h16, 32'h16, 32'h2, 32'h2, 32'h2,
                                  32'h8, 32'h8, 32'h8, 32'h8, 32'hE, 32'hE, 32'h6, 32'h6,
                                  32'hFFFFFFF3, 32'h16, 32'h16};

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_alu_out", 64'(alu_out), 64'(0));
        chk("reset_flags", 64'(flags), 64'(1));
        chk("reset_div_zero", 64'(div_zero), 64'(0));
        chk("reset_op", 64'(op), 64'(0));

        for (int i = 0; i < 18; i++)
            do_op($sformatf("sweep%0d", i), sw_opc[i], 32'h0000000C, 32'h0000000A,
                  sw_op[i], sw_res[i], (i == 15) ? 2'b10 : 2'b00, 1'b0, 1);

        do_op("mul", 5'b00110, 32'h00012345, 32'h00000100, 3'd2, 32'h01234500, 2'b00, 1'b0, W + 1);
        do_op("mul_ff", 5'b00110, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 32'h00000001, 2'b00, 1'b0, W + 1);
        do_op("div", 5'b01000, 32'd100, 32'd7, 3'd3, 32'd14, 2'b00, 1'b0, W + 1);
        do_op("div_big", 5'b01000, 32'hFFFFFFFF, 32'h80000001, 3'd3, 32'd1, 2'b00, 1'b0, W + 1);
        do_op("div_sh", 5'b01000, 32'hF0000000, 32'h10, 3'd3, 32'h0F000000, 2'b00, 1'b0, W + 1);
        do_op("div0", 5'b01000, 32'd5, 32'd0, 3'd3, 32'hFFFFFFFF, 2'b10, 1'b1, 1);

        do_op("add_ovf", 5'b00010, 32'h7FFFFFFF, 32'd1, 3'd0, 32'h80000000, 2'b10, 1'b0, 1);
`ifdef ALU_OVERFLOW_EN
        chk("add_ovf_flags_full", 64'(flags), 64'(3'b110));
`else
        chk("add_ovf_flags_full", 64'(flags), 64'(2'b10));
`endif

        // Backpressure: result must hold while the consumer stalls.
        @(posedge clk); #1 out_ready = 1'b0;
        do_op("sub_eq", 5'b00100, 32'd5, 32'd5, 3'd1, 32'd0, 2'b01, 1'b0, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_res", 64'(alu_out), 64'(0));
            chk("hold_flags", 64'(flags[1:0]), 64'(2'b01));
            chk("hold_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; opcode = 5'b00010; a = 32'd3; b = 32'd4;
        @(negedge clk);
        chk("b2b_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 64'(out_valid), 64'(1));
        chk("b2b_res", 64'(alu_out), 64'(7));

        // Reset in the middle of a long divide.
        @(posedge clk); #1;
        in_valid = 1'b1; opcode = 5'b01000; a = 32'hFFFFFFFF; b = 32'd3;
        @(negedge clk);
        chk("div_rst_accept", 64'(in_ready), 64'(1));
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_alu_out", 64'(alu_out), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        do_op("add_after_rst", 5'b00010, 32'd1, 32'd1, 3'd0, 32'd2, 2'b00, 1'b0, 1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
`default_nettype wire
